// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared lane count, FSM state and lane index types for the memory stage
package gpu_pkg;

  localparam int LANES = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  typedef logic [1:0] lane_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - single-port data-memory request/ack handshake
interface mem_access_stage_if #(
  parameter int N      = 18,
  parameter int ADDR_W = 16
) ();

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [N-1:0]      mem_wdata;
  logic [N-1:0]      mem_rdata;
  logic              mem_ack;

  // The pipeline stage issues requests; the memory answers with data and ack.
  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );

endinterface

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - ack watchdog counter with clear/enable and a single expired flag
module mem_watchdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // Count enabled cycles since the last clear; hold once the limit is reached.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && !expired) begin
      count <= count + CW'(1);
    end
  end

  // Expired on the TIMEOUT-th consecutive enabled cycle without a clear.
  assign expired = en && (count == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory stage: serial 3-lane load/store sequencer, optional MEM_TIMEOUT_EN watchdog
module mem_access_stage
  import gpu_pkg::*;
#(
  parameter int N       = 18,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [N-1:0]          alu_result [0:LANES-1],
  input  logic [N-1:0]          write_data [0:LANES-1],
  input  logic [3:0]            wa3,
  input  logic                  pcsrc,
  input  logic                  regwrite,
  input  logic                  memtoreg,
  input  logic                  memwrite,
  output logic                  stall,
  mem_access_stage_if.master    mem,
  output logic                  out_valid,
  output logic [N-1:0]          read_data_o [0:LANES-1],
  output logic [N-1:0]          alu_out_o [0:LANES-1],
  output logic [3:0]            wa3_o,
  output logic                  pcsrc_o,
  output logic                  regwrite_o,
  output logic                  memtoreg_o,
  output logic                  mem_err
);

  mem_state_t        state, state_next;
  lane_t             lane;
  logic              mem_op;
  logic              is_load;
  logic              last_ack;
  logic              timeout;
  logic [ADDR_W-1:0] base;

  // Upstream holds the instruction while stalled, so its fields stay usable throughout ACCESS.
  assign mem_op   = in_valid && (memtoreg || memwrite);
  assign is_load  = !memwrite;
  assign base     = alu_result[0][ADDR_W-1:0];
  assign last_ack = mem.mem_ack && (lane == lane_t'(LANES - 1));

`ifdef MEM_TIMEOUT_EN
  logic wd_expired;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state != ACCESS) || mem.mem_ack),
    .en      (state == ACCESS),
    .expired (wd_expired)
  );

  // An ack arriving on the limit cycle still wins over the timeout.
  assign timeout = wd_expired && !mem.mem_ack;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_err <= 1'b0;
    end else if (timeout) begin
      mem_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
  assign mem_err        = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; DONE never samples the inputs, so a held load is not re-issued.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (mem_op) state_next = ACCESS;
      ACCESS:  if (timeout || last_ack) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake and stall outputs; stall is gated by reset so it drops asynchronously too.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (state == ACCESS) begin
      mem.mem_req   = 1'b1;
      mem.mem_we    = memwrite;
      mem.mem_addr  = base + ADDR_W'(lane);
      mem.mem_wdata = write_data[lane];
    end
    stall = reset && ((state == ACCESS) || ((state == IDLE) && mem_op));
  end

  // Result registers and lane counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lane       <= '0;
      out_valid  <= 1'b0;
      wa3_o      <= '0;
      pcsrc_o    <= 1'b0;
      regwrite_o <= 1'b0;
      memtoreg_o <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        read_data_o[i] <= '0;
        alu_out_o[i]   <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          lane       <= '0;
          out_valid  <= in_valid && !mem_op;
          wa3_o      <= wa3;
          pcsrc_o    <= pcsrc;
          regwrite_o <= regwrite;
          memtoreg_o <= memtoreg;
          for (int i = 0; i < LANES; i++) begin
            read_data_o[i] <= '0;
            alu_out_o[i]   <= alu_result[i];
          end
        end
        ACCESS: begin
          if (timeout) begin
            out_valid  <= 1'b1;
            regwrite_o <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
              read_data_o[i] <= '0;
            end
          end else if (mem.mem_ack) begin
            if (is_load) begin
              read_data_o[lane] <= mem.mem_rdata;
            end
            lane      <= lane + lane_t'(1);
            out_valid <= last_ack;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb/tb_mem_access_stage.sv - scoreboard bench for mem_access_stage with a latency-configurable memory model
module tb_mem_access_stage;
  import gpu_pkg::*;

  localparam int N   = 18;
  localparam int AW  = 16;
  localparam int TMO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid;
  logic [N-1:0]  alu_result [0:2];
  logic [N-1:0]  write_data [0:2];
  logic [3:0]    wa3;
  logic          pcsrc, regwrite, memtoreg, memwrite;
  logic          stall, out_valid, pcsrc_o, regwrite_o, memtoreg_o, mem_err;
  logic [N-1:0]  read_data_o [0:2];
  logic [N-1:0]  alu_out_o [0:2];
  logic [3:0]    wa3_o;

  mem_access_stage_if #(.N(N), .ADDR_W(AW)) mem ();

  mem_access_stage #(.N(N), .ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(rst_n), .in_valid(in_valid),
    .alu_result(alu_result), .write_data(write_data), .wa3(wa3),
    .pcsrc(pcsrc), .regwrite(regwrite), .memtoreg(memtoreg), .memwrite(memwrite),
    .stall(stall), .mem(mem), .out_valid(out_valid),
    .read_data_o(read_data_o), .alu_out_o(alu_out_o), .wa3_o(wa3_o),
    .pcsrc_o(pcsrc_o), .regwrite_o(regwrite_o), .memtoreg_o(memtoreg_o),
    .mem_err(mem_err)
  );

  // Memory model: ack after ack_lat waiting cycles, optional suppression and spurious ack.
  logic [N-1:0] mem_arr [0:65535];
  int ack_lat = 0;
  bit no_ack = 1'b0;
  bit spur = 1'b0;
  int wcnt = 0;

  assign mem.mem_ack   = (mem.mem_req && !no_ack && (wcnt == ack_lat)) || spur;
  assign mem.mem_rdata = mem_arr[mem.mem_addr];

  always @(posedge clk) begin
    if (!mem.mem_req || mem.mem_ack) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem.mem_req && mem.mem_ack && mem.mem_we) mem_arr[mem.mem_addr] <= mem.mem_wdata;
  end

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          we;
    logic [N-1:0]  wdata;
  } acc_t;

  typedef struct packed {
    logic [2:0][N-1:0] alu;
    logic [2:0][N-1:0] rd;
    logic [3:0]        wa3;
    logic              pcsrc;
    logic              regwrite;
    logic              memtoreg;
    int                start;
    int                lat;
  } out_t;

  acc_t acc_q [$];
  out_t out_q [$];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int req_cycles = 0;
  logic prev_wait = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [N-1:0] prev_wdata;
  acc_t mon_acc;
  out_t mon_out;

  // Monitor: compares accesses and results against the scoreboards on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_wait = 1'b0;
    end else begin
      if (mem.mem_req) begin
        req_cycles++;
        check("out_valid_in_access", out_valid, 1'b0);
      end
      if (mem.mem_req && prev_wait) begin
        check("addr_stable", mem.mem_addr, prev_addr);
        check("wdata_stable", mem.mem_wdata, prev_wdata);
      end
      if (mem.mem_req && mem.mem_ack) begin
        if (acc_q.size() == 0) begin
          check("access_expected", acc_q.size(), 1);
        end else begin
          mon_acc = acc_q.pop_front();
          check("mem_addr", mem.mem_addr, mon_acc.addr);
          check("mem_we", mem.mem_we, mon_acc.we);
          check("mem_wdata", mem.mem_wdata, mon_acc.wdata);
        end
      end
      prev_wait  = mem.mem_req && !mem.mem_ack;
      prev_addr  = mem.mem_addr;
      prev_wdata = mem.mem_wdata;
      if (out_valid) begin
        if (out_q.size() == 0) begin
          check("result_expected", out_q.size(), 1);
        end else begin
          mon_out = out_q.pop_front();
          check("latency", cyc - mon_out.start, mon_out.lat);
          for (int i = 0; i < 3; i++) begin
            check($sformatf("alu_out_o[%0d]", i), alu_out_o[i], mon_out.alu[i]);
            check($sformatf("read_data_o[%0d]", i), read_data_o[i], mon_out.rd[i]);
          end
          check("wa3_o", wa3_o, mon_out.wa3);
          check("pcsrc_o", pcsrc_o, mon_out.pcsrc);
          check("regwrite_o", regwrite_o, mon_out.regwrite);
          check("memtoreg_o", memtoreg_o, mon_out.memtoreg);
        end
      end
    end
  end

  // Drive one instruction, push its expectations, hold it while the stage stalls.
  task automatic send(input logic mt, input logic mw, input logic rw, input logic [3:0] w,
                      input logic [N-1:0] a0, input logic [N-1:0] a1, input logic [N-1:0] a2,
                      input logic [N-1:0] d0, input logic [N-1:0] d1, input logic [N-1:0] d2,
                      output int st);
    out_t o;
    acc_t a;
    logic [N-1:0] d [3];
    logic [AW-1:0] b;
    bit released;
    @(posedge clk);
    #1;
    d[0] = d0; d[1] = d1; d[2] = d2;
    in_valid = 1'b1;
    alu_result[0] = a0; alu_result[1] = a1; alu_result[2] = a2;
    write_data[0] = d0; write_data[1] = d1; write_data[2] = d2;
    wa3 = w; pcsrc = 1'b0; regwrite = rw; memtoreg = mt; memwrite = mw;
    o = '0;
    o.alu[0] = a0; o.alu[1] = a1; o.alu[2] = a2;
    o.wa3 = w; o.regwrite = rw; o.memtoreg = mt; o.start = cyc; o.lat = 1;
    if (mt || mw) begin
      b = a0[AW-1:0];
      if (no_ack) begin
        o.regwrite = 1'b0;
        o.lat = 1 + TMO;
      end else begin
        for (int i = 0; i < 3; i++) begin
          a.addr = b + AW'(i);
          a.we = mw;
          a.wdata = d[i];
          acc_q.push_back(a);
          if (!mw) o.rd[i] = mem_arr[a.addr];
        end
        o.lat = 1 + 3 * (ack_lat + 1);
      end
    end
    out_q.push_back(o);
    st = 0;
    released = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!stall) begin
        released = 1'b1;
        break;
      end
      st++;
    end
    check("stall_released", released, 1'b1);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  int st;
  bit reached;

  initial begin
    in_valid = 1'b0;
    wa3 = '0; pcsrc = 1'b0; regwrite = 1'b0; memtoreg = 1'b0; memwrite = 1'b0;
    for (int i = 0; i < 3; i++) begin
      alu_result[i] = '0;
      write_data[i] = '0;
    end
    for (int i = 0; i < 65536; i++) mem_arr[i] = '0;
    mem_arr[16'h0010] = 18'h1A;
    mem_arr[16'h0011] = 18'h2B;
    mem_arr[16'h0012] = 18'h3C;
    mem_arr[16'h0021] = 18'h55;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_mem_req", mem.mem_req, 1'b0);
    check("rst_stall", stall, 1'b0);
    check("rst_mem_err", mem_err, 1'b0);
    check("rst_alu_out_o0", alu_out_o[0], '0);
    check("rst_read_data_o2", read_data_o[2], '0);
    check("rst_wa3_o", wa3_o, '0);
    check("rst_regwrite_o", regwrite_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pass-through, then another with a spurious ack that must be ignored.
    req_cycles = 0;
    send(1'b0, 1'b0, 1'b1, 4'd3, 18'd5, 18'd6, 18'd7, 18'd0, 18'd0, 18'd0, st);
    check("pt_stall_cycles", st, 0);
    spur = 1'b1;
    send(1'b0, 1'b0, 1'b1, 4'd9, 18'd100, 18'd200, 18'd300, 18'd0, 18'd0, 18'd0, st);
    idle();
    spur = 1'b0;
    repeat (2) @(posedge clk);
    check("pt_no_req", req_cycles, 0);

    // Zero-wait load at 0x0010.
    ack_lat = 0;
    send(1'b1, 1'b0, 1'b1, 4'd5, 18'h10, 18'd11, 18'd22, 18'd0, 18'd0, 18'd0, st);
    check("load_stall_cycles", st, 4);
    idle();
    repeat (2) @(posedge clk);

    // Store at 0xFFFF with a 2-cycle ack latency; addresses wrap.
    ack_lat = 2;
    send(1'b0, 1'b1, 1'b1, 4'd7, 18'h0FFFF, 18'd0, 18'd0, 18'd1, 18'd2, 18'd3, st);
    check("store_stall_cycles", st, 10);
    idle();
    repeat (2) @(posedge clk);
    check("store_mem_ffff", mem_arr[16'hFFFF], 18'd1);
    check("store_mem_0000", mem_arr[16'h0000], 18'd2);
    check("store_mem_0001", mem_arr[16'h0001], 18'd3);

    // Reset during the lane-1 wait aborts the load.
    ack_lat = 3;
    @(posedge clk);
    #1;
    in_valid = 1'b1; memtoreg = 1'b1; memwrite = 1'b0; regwrite = 1'b1;
    alu_result[0] = 18'h20;
    acc_q.push_back('{addr: 16'h0020, we: 1'b0, wdata: write_data[0]});
    reached = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (mem.mem_req && mem.mem_addr == 16'h0021) begin
        reached = 1'b1;
        break;
      end
    end
    check("reached_lane1", reached, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_mem_req", mem.mem_req, 1'b0);
    check("abort_stall", stall, 1'b0);
    check("abort_out_valid", out_valid, 1'b0);
    in_valid = 1'b0;
    acc_q.delete();
    out_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ack_lat = 1;
    send(1'b1, 1'b0, 1'b1, 4'd2, 18'h10, 18'd1, 18'd2, 18'd0, 18'd0, 18'd0, st);
    check("reload_stall_cycles", st, 7);

    // Back-to-back load then non-memory op.
    ack_lat = 0;
    send(1'b1, 1'b0, 1'b1, 4'd4, 18'h11, 18'd8, 18'd9, 18'd0, 18'd0, 18'd0, st);
    send(1'b0, 1'b0, 1'b1, 4'd6, 18'd40, 18'd41, 18'd42, 18'd0, 18'd0, 18'd0, st);
    check("b2b_second_stall", st, 0);
    idle();
    repeat (3) @(posedge clk);

`ifdef MEM_TIMEOUT_EN
    // No ack on lane 0: watchdog aborts and flags the error.
    no_ack = 1'b1;
    send(1'b1, 1'b0, 1'b1, 4'd1, 18'h10, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, st);
    check("timeout_stall_cycles", st, 1 + TMO);
    idle();
    no_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mem_err_set", mem_err, 1'b1);
    send(1'b0, 1'b0, 1'b1, 4'd8, 18'd3, 18'd2, 18'd1, 18'd0, 18'd0, 18'd0, st);
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("mem_err_sticky", mem_err, 1'b1);
`else
    #1;
    check("mem_err_tied", mem_err, 1'b0);
`endif

    repeat (5) @(posedge clk);
    check("acc_q_drained", acc_q.size(), 0);
    check("out_q_drained", out_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
